// File: rtl/filter_tag_sequencer_if.sv
// Filter tag multicast bus: one (row_tag, col_tag) pair per valid/ready handshake.
// The sequencer drives through the master modport; the consumer uses the slave modport.
interface filter_tag_sequencer_if #(
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 5
) ();
  logic                     tag_valid;
  logic                     tag_ready;
  logic [ROW_TAG_WIDTH-1:0] row_tag;
  logic [COL_TAG_WIDTH-1:0] col_tag;
  logic                     last_in_pass;

  modport master (
    output tag_valid,
    output row_tag,
    output col_tag,
    output last_in_pass,
    input  tag_ready
  );

  modport slave (
    input  tag_valid,
    input  row_tag,
    input  col_tag,
    input  last_in_pass,
    output tag_ready
  );
endinterface

// File: rtl/filter_tag_sequencer.sv
// Filter tag sequencer: walks pass > R > r > t and emits one tag pair per handshake.
// Optional macro FILTER_TAG_OFFSET_EN adds latched row/col placement offsets.
module filter_tag_sequencer #(
  parameter int R_WIDTH       = 4,
  parameter int r_WIDTH       = 2,
  parameter int t_WIDTH       = 3,
  parameter int STRIDE_WIDTH  = 3,
  parameter int PASS_WIDTH    = 8,
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [R_WIDTH-1:0]       R,
  input  logic [r_WIDTH-1:0]       r,
  input  logic [t_WIDTH-1:0]       t,
  input  logic [STRIDE_WIDTH-1:0]  col_stride,
  input  logic [PASS_WIDTH-1:0]    passes,
`ifdef FILTER_TAG_OFFSET_EN
  input  logic [ROW_TAG_WIDTH-1:0] row_offset,
  input  logic [COL_TAG_WIDTH-1:0] col_offset,
`endif
  output logic                     done,
  output logic                     busy,
  output logic                     cfg_error,
  filter_tag_sequencer_if.master   tag_bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOPING,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [R_WIDTH-1:0]      cfg_rows_q, cfg_rows_d;
  logic [r_WIDTH-1:0]      cfg_groups_q, cfg_groups_d;
  logic [t_WIDTH-1:0]      cfg_sets_q, cfg_sets_d;
  logic [STRIDE_WIDTH-1:0] cfg_stride_q, cfg_stride_d;
  logic [PASS_WIDTH-1:0]   cfg_passes_q, cfg_passes_d;
  logic [R_WIDTH-1:0]      row_cnt_q, row_cnt_d;
  logic [r_WIDTH-1:0]      grp_cnt_q, grp_cnt_d;
  logic [t_WIDTH-1:0]      set_cnt_q, set_cnt_d;
  logic [PASS_WIDTH-1:0]   pass_cnt_q, pass_cnt_d;
  logic                    cfg_error_q, cfg_error_d;

  logic start_accept;
  logic cfg_ok;
  logic set_last, grp_last, row_last, pass_last, sweep_last;
  logic looping;

  logic [ROW_TAG_WIDTH-1:0] row_off;
  logic [COL_TAG_WIDTH-1:0] col_off;

  // abort in IDLE suppresses a simultaneous start
  assign start_accept = (state_q == S_IDLE) && start && !abort;
  assign cfg_ok       = (R != '0) && (r != '0) && (t != '0) && (passes != '0);

  assign looping    = (state_q == S_LOOPING);
  assign set_last   = (set_cnt_q  == cfg_sets_q   - t_WIDTH'(1));
  assign grp_last   = (grp_cnt_q  == cfg_groups_q - r_WIDTH'(1));
  assign row_last   = (row_cnt_q  == cfg_rows_q   - R_WIDTH'(1));
  assign pass_last  = (pass_cnt_q == cfg_passes_q - PASS_WIDTH'(1));
  assign sweep_last = set_last && grp_last && row_last;

  // NOTE: every variable below gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cfg_rows_d   = cfg_rows_q;
    cfg_groups_d = cfg_groups_q;
    cfg_sets_d   = cfg_sets_q;
    cfg_stride_d = cfg_stride_q;
    cfg_passes_d = cfg_passes_q;
    row_cnt_d    = row_cnt_q;
    grp_cnt_d    = grp_cnt_q;
    set_cnt_d    = set_cnt_q;
    pass_cnt_d   = pass_cnt_q;
    cfg_error_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_accept) begin
          cfg_rows_d   = R;
          cfg_groups_d = r;
          cfg_sets_d   = t;
          cfg_stride_d = col_stride;
          cfg_passes_d = passes;
          if (!cfg_ok) begin
            cfg_error_d = 1'b1;
          end else begin
            state_d    = S_LOOPING;
            row_cnt_d  = '0;
            grp_cnt_d  = '0;
            set_cnt_d  = '0;
            pass_cnt_d = '0;
          end
        end
      end

      S_LOOPING: begin
        if (abort) begin
          state_d    = S_IDLE;
          row_cnt_d  = '0;
          grp_cnt_d  = '0;
          set_cnt_d  = '0;
          pass_cnt_d = '0;
        end else if (tag_bus.tag_ready) begin
          if (sweep_last && pass_last) begin
            state_d    = S_DONE;
            row_cnt_d  = '0;
            grp_cnt_d  = '0;
            set_cnt_d  = '0;
            pass_cnt_d = '0;
          end else if (!set_last) begin
            set_cnt_d = set_cnt_q + t_WIDTH'(1);
          end else begin
            set_cnt_d = '0;
            if (!grp_last) begin
              grp_cnt_d = grp_cnt_q + r_WIDTH'(1);
            end else begin
              grp_cnt_d = '0;
              if (!row_last) begin
                row_cnt_d = row_cnt_q + R_WIDTH'(1);
              end else begin
                row_cnt_d  = '0;
                pass_cnt_d = pass_cnt_q + PASS_WIDTH'(1);
              end
            end
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State advances on the falling edge to match the rest of the NoC controller.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cfg_rows_q   <= '0;
      cfg_groups_q <= '0;
      cfg_sets_q   <= '0;
      cfg_stride_q <= '0;
      cfg_passes_q <= '0;
      row_cnt_q    <= '0;
      grp_cnt_q    <= '0;
      set_cnt_q    <= '0;
      pass_cnt_q   <= '0;
      cfg_error_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q      <= state_d;
      cfg_rows_q   <= cfg_rows_d;
      cfg_groups_q <= cfg_groups_d;
      cfg_sets_q   <= cfg_sets_d;
      cfg_stride_q <= cfg_stride_d;
      cfg_passes_q <= cfg_passes_d;
      row_cnt_q    <= row_cnt_d;
      grp_cnt_q    <= grp_cnt_d;
      set_cnt_q    <= set_cnt_d;
      pass_cnt_q   <= pass_cnt_d;
      cfg_error_q  <= cfg_error_d;
    end
  end

`ifdef FILTER_TAG_OFFSET_EN
  logic [ROW_TAG_WIDTH-1:0] row_off_q, row_off_d;
  logic [COL_TAG_WIDTH-1:0] col_off_q, col_off_d;

  always_comb begin
    row_off_d = row_off_q;
    col_off_d = col_off_q;
    if (start_accept) begin
      row_off_d = row_offset;
      col_off_d = col_offset;
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      row_off_q <= '0;
      col_off_q <= '0;
    end else begin
      row_off_q <= row_off_d;
      col_off_q <= col_off_d;
    end
  end

  assign row_off = row_off_q;
  assign col_off = col_off_q;
`else
  assign row_off = '0;
  assign col_off = '0;
`endif

  // Arithmetic at port width equals the full-precision result taken modulo 2**width.
  assign tag_bus.tag_valid    = looping;
  assign tag_bus.last_in_pass = looping && sweep_last;
  assign tag_bus.row_tag      = looping ? (ROW_TAG_WIDTH'(row_cnt_q) + row_off) : '0;
  assign tag_bus.col_tag      = looping ? (COL_TAG_WIDTH'(set_cnt_q)
                                           + COL_TAG_WIDTH'(grp_cnt_q) * COL_TAG_WIDTH'(cfg_stride_q)
                                           + col_off) : '0;

  assign busy      = looping;
  assign done      = (state_q == S_DONE);
  assign cfg_error = cfg_error_q;

endmodule
